// File: rtl/rbz_line_display.sv
// rbz_line_display: parametrised VGA back end for the raycaster.
// Generates pixel timing and requests one wall trace per line from an
// external tracer. It latches the returned column and composites a centred
// wall span over a selectable background. Video outputs are registered and
// lag hpos/vpos by one cycle.
module rbz_line_display #(
    parameter int H_VIEW  = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_VIEW  = 480,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int RGB_W   = 2,
    parameter int SIZE_W  = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 hsync_n,
    output logic                 vsync_n,
    output logic [3*RGB_W-1:0]   rgb,
    output logic [9:0]           hpos,
    output logic [9:0]           vpos,
    input  logic [1:0]           bg_mode,
    output logic                 trace_start,
    output logic [9:0]           trace_row,
    input  logic                 trace_done,
    input  logic                 trace_side,
    input  logic [SIZE_W-1:0]    trace_size,
    output logic                 late,
    output logic [15:0]          late_count,
    output logic [15:0]          frame_count
);

    localparam int H_TOTAL  = H_VIEW + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VIEW + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VIEW + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VIEW + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    // Tracer handshake states. IDLE exists only until the first line ends.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [RGB_W-1:0] CH_MAX  = {RGB_W{1'b1}};
    localparam logic [RGB_W-1:0] CH_ZERO = {RGB_W{1'b0}};
    localparam logic [RGB_W-1:0] CH_L    = {1'b1, {(RGB_W-1){1'b0}}};
    localparam logic [RGB_W-1:0] CH_D    = {1'b0, {(RGB_W-1){1'b1}}};

    // Handshake: trace_start is a one-cycle request, and trace_row is valid
    // in that cycle. trace_done is a one-cycle result strobe, and
    // trace_side/trace_size are valid only while it is high. There is no
    // back-pressure. Only the first strobe after a request is taken.

    logic [9:0]        hcnt;
    logic [9:0]        vcnt;
    logic              hmax;
    logic              vmax;
    logic [9:0]        next_row;
    logic [0:0]        state;
    logic              got_result;
    logic              pend_side;
    logic [SIZE_W-1:0] pend_size;
    logic              line_side;
    logic [SIZE_W-1:0] line_size;
    logic              visible;
    logic              wall_hit;
    logic              bg_light;
    logic [SIZE_W:0]   half;
    logic [SIZE_W:0]   span_lo;
    logic [SIZE_W:0]   span_hi;
    logic [SIZE_W:0]   hcnt_ext;
    logic [3*RGB_W-1:0] pixel;

    localparam logic [SIZE_W:0] CENTER = (SIZE_W+1)'(H_VIEW / 2);

    assign hpos     = hcnt;
    assign vpos     = vcnt;
    assign hmax     = (hcnt == 10'(H_TOTAL - 1));
    assign vmax     = (vcnt == 10'(V_TOTAL - 1));
    assign next_row = vmax ? 10'd0 : vcnt + 10'd1;
    assign visible  = (hcnt < 10'(H_VIEW)) && (vcnt < 10'(V_VIEW));

    // Pixel and line counters, plus the frame counter that ticks on the double wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            frame_count <= '0;
        end else if (hmax) begin
            hcnt <= '0;
            vcnt <= next_row;
            if (vmax) frame_count <= frame_count + 16'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    // Tracer handshake: request at every line end and capture the first result.
    // At the next line end, promote the result or flag the line as late.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            trace_start <= 1'b0;
            trace_row   <= '0;
            got_result  <= 1'b0;
            pend_side   <= 1'b0;
            pend_size   <= '0;
            line_side   <= 1'b0;
            line_size   <= '0;
            late        <= 1'b0;
            late_count  <= '0;
        end else begin
            trace_start <= 1'b0;
            late        <= 1'b0;
            if (hmax) begin
                if (state == ST_BUSY) begin
                    // A strobe landing on hmax still belongs to the ending line.
                    if (got_result) begin
                        line_side <= pend_side;
                        line_size <= pend_size;
                    end else if (trace_done) begin
                        line_side <= trace_side;
                        line_size <= trace_size;
                    end else begin
                        late <= 1'b1;
                        if (late_count != 16'hFFFF) late_count <= late_count + 16'd1;
                    end
                end
                state       <= ST_BUSY;
                trace_start <= 1'b1;
                trace_row   <= next_row;
                got_result  <= 1'b0;
            end else if (state == ST_BUSY && trace_done && !got_result) begin
                pend_side  <= trace_side;
                pend_size  <= trace_size;
                got_result <= 1'b1;
            end
        end
    end

    // Wall span and background selection for the current pixel.
    always_comb begin
        hcnt_ext = (SIZE_W+1)'(hcnt);
        half     = {1'b0, line_size} >> 1;
        span_lo  = (half > CENTER) ? '0 : CENTER - half;
        span_hi  = CENTER + half;
        wall_hit = visible &&
                   ((line_size >= SIZE_W'(H_VIEW)) ||
                    (hcnt_ext >= span_lo && hcnt_ext < span_hi));
        bg_light = 1'b0;
        case (bg_mode)
            2'd0:    bg_light = (hcnt < 10'(H_VIEW / 2));
            2'd1:    bg_light = (vcnt < 10'(V_VIEW / 2));
            2'd3:    bg_light = hcnt[4] ^ vcnt[4];
            default: bg_light = 1'b0;
        endcase
        pixel = '0;
        if (visible) begin
            if (wall_hit)
                pixel = line_side ? {CH_ZERO, CH_L, CH_MAX} : {CH_ZERO, CH_ZERO, CH_MAX};
            else if (bg_mode != 2'd2)
                pixel = bg_light ? {CH_L, CH_L, CH_L} : {CH_D, CH_D, CH_D};
        end
    end

    // Register video so that colour and syncs share one cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
            rgb     <= '0;
        end else begin
            hsync_n <= !(hcnt >= 10'(HS_START) && hcnt < 10'(HS_END));
            vsync_n <= !(vcnt >= 10'(VS_START) && vcnt < 10'(VS_END));
            rgb     <= pixel;
        end
    end

endmodule

// File: tb/tb_rbz_line_display.sv
// Testbench for rbz_line_display, scaled to small timing parameters.
// A reference model computes each cycle's outputs from the elapsed cycle
// count. A monitor compares the DUT outputs against the expected queue.
module tb_rbz_line_display;

    localparam int HV = 64, HF = 4, HSY = 8, HB = 4;
    localparam int VV = 20, VF = 2, VSY = 2, VB = 3;
    localparam int RW = 2, SW = 11;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;
    localparam int FRAME = HT * VT;

    logic          clk = 1'b0;
    logic          reset;
    logic          hsync_n, vsync_n;
    logic [3*RW-1:0] rgb;
    logic [9:0]    hpos, vpos;
    logic [1:0]    bg_mode;
    logic          trace_start;
    logic [9:0]    trace_row;
    logic          trace_done, trace_side;
    logic [SW-1:0] trace_size;
    logic          late;
    logic [15:0]   late_count, frame_count;

    rbz_line_display #(
        .H_VIEW(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_VIEW(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .RGB_W(RW), .SIZE_W(SW)
    ) dut (
        .clk(clk), .reset(reset), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .rgb(rgb), .hpos(hpos), .vpos(vpos), .bg_mode(bg_mode),
        .trace_start(trace_start), .trace_row(trace_row),
        .trace_done(trace_done), .trace_side(trace_side), .trace_size(trace_size),
        .late(late), .late_count(late_count), .frame_count(frame_count)
    );

    // Clock
    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  hpos;
        logic [9:0]  vpos;
        logic        hs_n;
        logic        vs_n;
        logic [5:0]  rgb;
        logic        start;
        logic [9:0]  row;
        logic        late;
        logic [15:0] lc;
        logic [15:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   started  = 0;

    // Reference model state.
    int m_t = 0;
    int disp_side = 0, disp_size = 0;
    int res_side = 0, res_size = 0;
    bit got = 0, in_flight = 0;
    int lc = 0, last_row = 0;
    int pos1 = -1, pos2 = -1;

    function automatic logic [5:0] ref_pixel(input int h, input int v, input int side,
                                             input int size, input int bg);
        int half, lo, hi;
        bit light;
        if (!(h < HV && v < VV)) return 6'b000000;
        half = size / 2;
        lo = HV / 2 - half;
        if (lo < 0) lo = 0;
        hi = HV / 2 + half;
        if (size >= HV || (h >= lo && h < hi))
            return (side != 0) ? 6'b001011 : 6'b000011;
        case (bg)
            0: light = (h < HV / 2);
            1: light = (v < VV / 2);
            3: light = ((h / 16) % 2) != ((v / 16) % 2);
            default: return 6'b000000;
        endcase
        return light ? 6'b101010 : 6'b010101;
    endfunction

    function automatic int pick_size();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 2047;
        if (r == 1) return 0;
        if (r == 2) return $urandom_range(62, 66);
        return $urandom_range(0, 60);
    endfunction

    // Decide this line's tracer behaviour: no reply, reply on hmax, two replies, or one.
    task automatic new_plan();
        int r;
        r = $urandom_range(0, 9);
        pos1 = -1;
        pos2 = -1;
        if (r == 2) pos1 = HT - 1;
        else if (r == 3) begin
            pos1 = $urandom_range(0, 40);
            pos2 = pos1 + $urandom_range(1, 30);
        end else if (r > 3) pos1 = $urandom_range(0, HT - 1);
    endtask

    // Driver and model: drive one edge's inputs, then push the expected post-edge outputs.
    task automatic step(input logic rst);
        int h, v, tot;
        exp_t e;
        @(negedge clk);
        h = m_t % HT;
        v = (m_t / HT) % VT;
        if (h == 0) new_plan();
        reset      = rst;
        bg_mode    = 2'($urandom_range(0, 3));
        trace_done = (h == pos1) || (h == pos2);
        trace_side = 1'($urandom_range(0, 1));
        trace_size = SW'(pick_size());
        e = '0;
        if (rst) begin
            m_t = 0; disp_side = 0; disp_size = 0; got = 0; in_flight = 0;
            lc = 0; last_row = 0;
            e.hs_n = 1'b1;
            e.vs_n = 1'b1;
        end else begin
            e.rgb  = ref_pixel(h, v, disp_side, disp_size, int'(bg_mode));
            e.hs_n = !(h >= HV + HF && h < HV + HF + HSY);
            e.vs_n = !(v >= VV + VF && v < VV + VF + VSY);
            if (trace_done && in_flight && !got) begin
                got = 1;
                res_side = int'(trace_side);
                res_size = int'(trace_size);
            end
            if (h == HT - 1) begin
                if (in_flight) begin
                    if (got) begin
                        disp_side = res_side;
                        disp_size = res_size;
                    end else begin
                        e.late = 1'b1;
                        if (lc < 65535) lc++;
                    end
                end
                in_flight = 1;
                got = 0;
                e.start = 1'b1;
                last_row = (v + 1) % VT;
            end
            m_t++;
        end
        tot    = m_t;
        e.hpos = 10'(tot % HT);
        e.vpos = 10'((tot / HT) % VT);
        e.fc   = 16'((tot / FRAME) % 65536);
        e.row  = 10'(last_row);
        e.lc   = 16'(lc);
        exp_q.push_back(e);
        started = 1;
    endtask

    // Monitor: pop one expectation per clock and compare just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL queue_empty at %0t: DUT cycle without expectation", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (rgb !== e.rgb || hsync_n !== e.hs_n || vsync_n !== e.vs_n) begin
                        failures++;
                        $display("FAIL video at %0t: got rgb=%b hs_n=%b vs_n=%b, expected rgb=%b hs_n=%b vs_n=%b",
                                 $time, rgb, hsync_n, vsync_n, e.rgb, e.hs_n, e.vs_n);
                    end
                    checks++;
                    if (hpos !== e.hpos || vpos !== e.vpos || frame_count !== e.fc) begin
                        failures++;
                        $display("FAIL counters at %0t: got hpos=%0d vpos=%0d frame=%0d, expected hpos=%0d vpos=%0d frame=%0d",
                                 $time, hpos, vpos, frame_count, e.hpos, e.vpos, e.fc);
                    end
                    checks++;
                    if (trace_start !== e.start || trace_row !== e.row || late !== e.late ||
                        late_count !== e.lc) begin
                        failures++;
                        $display("FAIL tracer at %0t: got start=%b row=%0d late=%b late_count=%0d, expected start=%b row=%0d late=%b late_count=%0d",
                                 $time, trace_start, trace_row, late, late_count,
                                 e.start, e.row, e.late, e.lc);
                    end
                end
            end
        end
    end

    // Stimulus sequence and final report.
    initial begin
        reset      = 1'b1;
        bg_mode    = 2'd0;
        trace_done = 1'b0;
        trace_side = 1'b0;
        trace_size = '0;
        repeat (3) step(1'b1);
        repeat (2 * FRAME + 300) step(1'b0);
        // Assert reset in the middle of a visible line.
        while ((m_t % HT) != 30) step(1'b0);
        repeat (2) step(1'b1);
        repeat (FRAME + 200) step(1'b0);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
